// File: rtl/tms4464_responder_if.sv
// tms4464_responder_if: multiplexed-address DRAM pin bundle shared by controller and responder
interface tms4464_responder_if;
  logic [7:0] ram_addr;
  logic [3:0] ram_dq_in;
  logic [3:0] ram_dq_out;
  logic       ram_dq_oe;
  logic       ram_we_;
  logic       ram_oe_;
  logic       ram_ras_;
  logic       ram_cas_;
  modport master (output ram_addr, ram_dq_in, ram_we_, ram_oe_, ram_ras_, ram_cas_,
                  input ram_dq_out, ram_dq_oe);
  modport slave  (input ram_addr, ram_dq_in, ram_we_, ram_oe_, ram_ras_, ram_cas_,
                  output ram_dq_out, ram_dq_oe);
endinterface

// File: rtl/tms4464_responder.sv
// tms4464_responder: device-side 64Kx4 DRAM emulator with refresh audit and protocol checks
module tms4464_responder #(
  parameter int          DEPTH_BITS     = 12,
  parameter int          TRAS_MIN       = 4,
  parameter logic [23:0] REFRESH_WINDOW = 24'd200000
) (
  input  logic               clk,
  input  logic               rst_n,
  tms4464_responder_if.slave bus,
  output logic [15:0]        access_cnt,
  output logic [15:0]        refresh_cnt,
  output logic               proto_err,
  output logic               refresh_err
);
  typedef enum logic [2:0] {IDLE, ROW_OPEN, COL_OPEN, CBR_ARM, CBR} state_t;
  localparam logic [7:0] TRAS_Q = 8'(TRAS_MIN);
  state_t state, nxt;
  logic ras_q, cas_q, we_q, oe_q;
  logic [7:0] row, col, rcnt, cbr_row, tras, mrow;
  logic cas_seen, wrote, rd_done;
  logic [255:0] row_seen;
  logic [23:0] win;
  logic [3:0] mem [1<<DEPTH_BITS];
  logic ras_fall, ras_rise, cas_fall, cas_rise, we_fall;
  logic early_wr, late_any, late_wr, we_err, cbr_err, tras_err;
  logic ras_close, ref_inc, rd, rd_acc, win_end, wr;
  logic [15:0] full;
  logic [DEPTH_BITS-1:0] idx;
  assign ras_fall  = ras_q & ~bus.ram_ras_;
  assign ras_rise  = ~ras_q & bus.ram_ras_;
  assign cas_fall  = cas_q & ~bus.ram_cas_;
  assign cas_rise  = ~cas_q & bus.ram_cas_;
  assign we_fall   = we_q & ~bus.ram_we_;
  assign ras_close = ras_rise & (state == ROW_OPEN || state == COL_OPEN || state == CBR);
  assign early_wr  = state == ROW_OPEN && !ras_rise && cas_fall && !bus.ram_we_;
  assign late_any  = state == COL_OPEN && !ras_rise && !bus.ram_cas_ && we_fall;
  assign late_wr   = late_any & ~wrote;
  assign we_err    = late_any & wrote;
  assign cbr_err   = state == CBR_ARM && !ras_fall && cas_rise;
  assign tras_err  = ras_close && tras < TRAS_Q;
  assign mrow      = state == CBR ? cbr_row : row;
  assign ref_inc   = ras_rise && ((state == ROW_OPEN && !cas_seen) || state == CBR);
  // read needs the registered strobes to be settled and the live pins still asserted
  assign rd        = state == COL_OPEN && !ras_rise && !cas_q && !oe_q && we_q &&
                     !bus.ram_cas_ && !bus.ram_oe_ && bus.ram_we_;
  assign rd_acc    = rd & ~bus.ram_dq_oe & ~rd_done;
  assign win_end   = win == REFRESH_WINDOW - 24'd1;
  assign full      = {row, early_wr ? bus.ram_addr : col};
  assign idx       = full[DEPTH_BITS-1:0];
  assign wr        = (early_wr | late_wr) & rst_n;
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = (ras_fall & bus.ram_cas_) ? ROW_OPEN : (cas_fall & bus.ram_ras_) ? CBR_ARM : IDLE;
      ROW_OPEN: nxt = ras_rise ? IDLE : (cas_fall & bus.ram_we_) ? COL_OPEN : ROW_OPEN;
      COL_OPEN: nxt = ras_rise ? IDLE : cas_rise ? ROW_OPEN : COL_OPEN;
      CBR_ARM:  nxt = ras_fall ? CBR : cas_rise ? IDLE : CBR_ARM;
      CBR:      nxt = ras_rise ? IDLE : CBR;
      default:  nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk) state <= !rst_n ? IDLE : nxt;
  always_ff @(posedge clk) if (wr) mem[idx] <= bus.ram_dq_in;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      {ras_q, cas_q, we_q, oe_q} <= '1;
      row <= '0;
      col <= '0;
      rcnt <= '0;
      cbr_row <= '0;
      tras <= '0;
      cas_seen <= 1'b0;
      wrote <= 1'b0;
      rd_done <= 1'b0;
      row_seen <= '0;
      win <= '0;
      access_cnt <= '0;
      refresh_cnt <= '0;
      proto_err <= 1'b0;
      refresh_err <= 1'b0;
      bus.ram_dq_oe <= 1'b0;
      bus.ram_dq_out <= '0;
    end else begin
      {ras_q, cas_q, we_q, oe_q} <= {bus.ram_ras_, bus.ram_cas_, bus.ram_we_, bus.ram_oe_};
      if (state == IDLE && nxt == ROW_OPEN) begin
        row <= bus.ram_addr;
        cas_seen <= 1'b0;
      end
      if (state == ROW_OPEN && cas_fall && !ras_rise) begin
        col <= bus.ram_addr;
        cas_seen <= 1'b1;
        wrote <= 1'b0;
        rd_done <= 1'b0;
      end
      if (state == CBR_ARM && ras_fall) begin
        cbr_row <= rcnt;
        rcnt <= rcnt + 8'd1;
      end
      tras <= ras_fall ? 8'd1 : (!bus.ram_ras_ && tras != 8'hff) ? tras + 8'd1 : tras;
      if (late_wr) wrote <= 1'b1;
      if (rd_acc) rd_done <= 1'b1;
      if (early_wr | late_wr | rd_acc) access_cnt <= access_cnt + 16'd1;
      if (ref_inc) refresh_cnt <= refresh_cnt + 16'd1;
      if (we_err | cbr_err | tras_err) proto_err <= 1'b1;
      win <= win_end ? '0 : win + 24'd1;
      // a mark on the boundary cycle lands in the freshly cleared bitmap
      if (win_end) begin
        refresh_err <= refresh_err | ~&row_seen;
        row_seen <= '0;
      end
      if (ras_close) row_seen[mrow] <= 1'b1;
      bus.ram_dq_oe <= rd;
      if (rd) bus.ram_dq_out <= mem[idx];
    end
  end
endmodule

// File: tb/tb_tms4464_responder.sv
// tb_tms4464_responder: randomized DRAM-cycle stimulus with a read scoreboard and nybble-array model
module tb_tms4464_responder;
  localparam int TRAS = 4;
  localparam int W = 4000;
  typedef struct { logic [3:0] d; int c; } exp_t;
  logic clk = 0, rst_n = 0;
  logic [15:0] access_cnt, refresh_cnt;
  logic proto_err, refresh_err;
  int total = 0, bad = 0, cyc = 0, rel = 0;
  int acc_exp = 0, ref_exp = 0, ras_start = 0, op = 0, j = 0;
  logic [7:0] cur_row = 0, r = 0, c = 0;
  logic [3:0] d = 0;
  logic [3:0] model [4096];
  logic [7:0] wr_r [$];
  logic [7:0] wr_c [$];
  exp_t sb [$];
  exp_t mon_e;
  logic oe_prev = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  tms4464_responder_if bus();
  tms4464_responder #(.DEPTH_BITS(12), .TRAS_MIN(TRAS), .REFRESH_WINDOW(24'(W))) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .access_cnt(access_cnt),
    .refresh_cnt(refresh_cnt), .proto_err(proto_err), .refresh_err(refresh_err));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  function automatic int ix(input logic [7:0] rr, input logic [7:0] cc);
    return (int'(rr) * 256 + int'(cc)) % 4096;
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic idle_pins;
    bus.ram_ras_ = 1; bus.ram_cas_ = 1; bus.ram_we_ = 1; bus.ram_oe_ = 1;
  endtask
  task automatic do_reset;
    rst_n = 0; idle_pins(); tick(); tick();
    rst_n = 1; rel = cyc; acc_exp = 0; ref_exp = 0;
  endtask
  task automatic ras_open(input logic [7:0] rr);
    bus.ram_addr = rr; bus.ram_ras_ = 0; cur_row = rr; ras_start = cyc; tick();
  endtask
  task automatic ras_close;
    while (cyc - ras_start < TRAS) tick();
    bus.ram_ras_ = 1; tick();
  endtask
  task automatic early_write(input logic [7:0] cc, input logic [3:0] dd);
    bus.ram_addr = cc; bus.ram_dq_in = dd; bus.ram_we_ = 0; bus.ram_cas_ = 0; tick();
    bus.ram_cas_ = 1; bus.ram_we_ = 1; tick();
    model[ix(cur_row, cc)] = dd; acc_exp++;
  endtask
  task automatic late_write(input logic [7:0] cc, input logic [3:0] dd, input bit extra);
    bus.ram_addr = cc; bus.ram_we_ = 1; bus.ram_oe_ = 1; bus.ram_cas_ = 0; tick();
    bus.ram_dq_in = dd; bus.ram_we_ = 0; tick();
    bus.ram_we_ = 1; tick();
    if (extra) begin
      bus.ram_dq_in = ~dd; bus.ram_we_ = 0; tick();
      bus.ram_we_ = 1; tick();
    end
    bus.ram_cas_ = 1; tick();
    model[ix(cur_row, cc)] = dd; acc_exp++;
  endtask
  task automatic rd_cell(input logic [7:0] cc);
    bus.ram_addr = cc; bus.ram_we_ = 1; bus.ram_oe_ = 0; bus.ram_cas_ = 0;
    sb.push_back('{model[ix(cur_row, cc)], cyc + 2});
    tick(); tick(); tick();
    bus.ram_cas_ = 1; bus.ram_oe_ = 1; tick();
    acc_exp++;
  endtask
  task automatic cbr;
    bus.ram_cas_ = 0; tick();
    bus.ram_ras_ = 0; ras_start = cyc; tick();
    while (cyc - ras_start < TRAS) tick();
    bus.ram_ras_ = 1; tick();
    bus.ram_cas_ = 1; tick();
    ref_exp++;
  endtask
  task automatic ras_only(input logic [7:0] rr);
    ras_open(rr); ras_close(); ref_exp++;
  endtask
  task automatic tras_test(input int n);
    bus.ram_addr = 8'h66; bus.ram_ras_ = 0;
    repeat (n) tick();
    bus.ram_ras_ = 1; tick(); tick();
    ref_exp++;
  endtask

  always @(negedge clk) begin
    if (rst_n && bus.ram_dq_oe && !oe_prev) begin
      if (sb.size() == 0) chk("spurious_oe", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("rd_data", 32'(bus.ram_dq_out), 32'(mon_e.d));
        chk("rd_latency", cyc, mon_e.c);
      end
    end
    oe_prev = bus.ram_dq_oe;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: no finish within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_pins(); bus.ram_addr = 0; bus.ram_dq_in = 0;
    tick(); tick(); tick();
    chk("rst_dq_oe", bus.ram_dq_oe, 0);
    chk("rst_dq_out", bus.ram_dq_out, 0);
    chk("rst_access", access_cnt, 0);
    chk("rst_refresh", refresh_cnt, 0);
    chk("rst_proto", proto_err, 0);
    chk("rst_referr", refresh_err, 0);
    rst_n = 1; rel = cyc;
    repeat (256) cbr();
    chk("cbr_count", refresh_cnt, 256);
    while (cyc < rel + W + 2) tick();
    chk("win1_full_refresh", refresh_err, 0);
    for (int i = 0; i < 256; i++) if (i != 8'h7F) ras_only(8'(i));
    chk("ras_only_count", refresh_cnt, ref_exp);
    while (cyc < rel + 2 * W + 2) tick();
    chk("win2_missing_row", refresh_err, 1);
    chk("refresh_no_proto", proto_err, 0);

    do_reset();
    ras_open(8'h12); early_write(8'h34, 4'h5); ras_close();
    ras_open(8'h12); rd_cell(8'h34); ras_close();
    chk("ew_rd_access", access_cnt, 2);
    ras_open(8'h21);
    for (int k = 0; k < 4; k++) early_write(8'(k), 4'(k + 2));
    for (int k = 0; k < 4; k++) rd_cell(8'(k));
    ras_close();
    chk("page_refresh_unchanged", refresh_cnt, ref_exp);
    repeat (40) begin
      op = $urandom_range(0, 2);
      if (op == 2 && wr_r.size() > 0) begin
        j = $urandom_range(0, wr_r.size() - 1);
        ras_open(wr_r[j]); rd_cell(wr_c[j]);
      end else begin
        r = 8'($urandom); c = 8'($urandom); d = 4'($urandom);
        ras_open(r);
        if (op == 0) early_write(c, d); else late_write(c, d, 0);
        wr_r.push_back(r); wr_c.push_back(c);
      end
      ras_close();
    end
    chk("rand_access", access_cnt, acc_exp);
    chk("rand_refresh", refresh_cnt, ref_exp);
    tras_test(TRAS);
    chk("tras_exact_ok", proto_err, 0);
    ras_open(8'h40); late_write(8'h55, 4'hA, 1); ras_close();
    chk("double_we_proto", proto_err, 1);
    ras_open(8'h40); rd_cell(8'h55); ras_close();
    chk("late_access", access_cnt, acc_exp);

    do_reset();
    tras_test(TRAS - 1);
    chk("tras_short_proto", proto_err, 1);
    chk("tras_short_refresh", refresh_cnt, 1);

    do_reset();
    ras_open(8'h12);
    bus.ram_addr = 8'h34; bus.ram_we_ = 1; bus.ram_oe_ = 0; bus.ram_cas_ = 0;
    sb.push_back('{model[ix(8'h12, 8'h34)], cyc + 2});
    tick(); tick(); tick();
    chk("pre_reset_oe", bus.ram_dq_oe, 1);
    rst_n = 0; idle_pins(); tick();
    chk("reset_oe_drop", bus.ram_dq_oe, 0);
    chk("reset_access", access_cnt, 0);
    chk("reset_refresh", refresh_cnt, 0);
    rst_n = 1; acc_exp = 0; ref_exp = 0; tick();
    ras_open(8'h12); rd_cell(8'h34); ras_close();
    chk("post_reset_access", access_cnt, 1);
    repeat (5) tick();
    chk("scoreboard_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/tms4464_responder.md
# tms4464_responder

Synthesizable device-side emulator of a 64K×4 multiplexed-address DRAM (TMS4464 pinout). It lets the `tms4464` controller and the memory-sweep test harness run on the FPGA with no physical chip fitted. It sits on the same `ram_*` pins the controller drives. It decodes RAS/CAS/WE/OE cycles against an internal nybble store, drives read data back, counts refreshes and flags protocol and refresh violations for the display and LEDs.

## Interface
- `DEPTH_BITS`, 12: log2 of the number of stored nybbles; the cell index is `{row,col}[DEPTH_BITS-1:0]`, and higher rows alias.
- `TRAS_MIN`, 4: minimum RAS-low width in clk cycles.
- `REFRESH_WINDOW`, 24'd200000: clk cycles per refresh-audit window (4 ms at 50 MHz).
- `clk` in 1: system clock; all logic on its rising edge.
- `rst_n` in 1: synchronous, active-low reset.
- `ram_addr` in 8: multiplexed row/column address.
- `ram_dq_in` in 4: write data from the controller side of the shared bus.
- `ram_dq_out` out 4: read data.
- `ram_dq_oe` out 1: high while `ram_dq_out` must drive the bus.
- `ram_we_`, `ram_oe_`, `ram_ras_`, `ram_cas_` in 1 each: active-low strobes.
- `access_cnt` out 16: completed read and write accesses; wraps at 16'hffff→0.
- `refresh_cnt` out 16: completed refresh cycles (RAS-only plus CAS-before-RAS); wraps.
- `proto_err` out 1: sticky protocol-violation flag.
- `refresh_err` out 1: sticky; set when a refresh window ends with any row unrefreshed.

## Operation
- Strobes are sampled once into `*_q` registers. An edge is a difference between the current pin value and its `_q` register. Only registered edges act.
- RAS fall with CAS high: latch `row <= ram_addr` and enter `ROW_OPEN`. Start the RAS-low width counter.
- CAS fall during `ROW_OPEN`: latch `col <= ram_addr`.
  - If WE is low at the same sample, this is an early write: `mem[idx] <= ram_dq_in` and `access_cnt` increments.
  - Otherwise enter `COL_OPEN`.
- `COL_OPEN`, late write: a WE fall while CAS is still low writes `ram_dq_in` on that cycle and increments `access_cnt`. At most one write is allowed per CAS-low period. Further WE toggles set `proto_err` and do not write.
- `COL_OPEN`, read: OE low with WE high drives `ram_dq_out = mem[idx]` and sets `ram_dq_oe = 1`. `access_cnt` increments once per CAS-low period on the first cycle `ram_dq_oe` rises.
- CAS-before-RAS refresh:
  - A CAS fall while RAS is high enters `CBR_ARM`.
  - A RAS fall in `CBR_ARM` enters `CBR`. An internal 8-bit refresh row counter marks its row refreshed, then increments.
  - A CAS rise in `CBR_ARM` returns to `IDLE` and sets `proto_err`.
- RAS-only refresh: RAS rises from `ROW_OPEN` with no CAS fall.
- Row refreshed: any RAS rise from `ROW_OPEN`, `COL_OPEN` or `CBR` marks the row refreshed and returns to `IDLE`. For `ROW_OPEN` and `COL_OPEN` the row is `row`. For `CBR` it is the refresh row counter value captured on entry. `refresh_cnt` increments only on exit from `ROW_OPEN` (no CAS) and from `CBR`.
- tRAS check: a RAS rise after fewer than `TRAS_MIN` cycles low sets `proto_err`. The cycle still completes normally.
- Refresh audit:
  - A 256-bit `row_seen` bitmap records refreshed rows.
  - A window counter counts to `REFRESH_WINDOW-1`. On the cycle it is reached, `refresh_err` sets if any bit is 0, then the bitmap clears and the counter wraps to 0.
  - A mark on that same cycle counts toward the new window.
- CAS rise from `COL_OPEN` returns to `ROW_OPEN`, which allows page-mode accesses on the same row.
- Sticky flags clear only on reset. Memory contents are not reset.

## Timing
- Reset values:
  - `ram_dq_oe=0`, `ram_dq_out=0`, counters 0, both flags 0.
  - State `IDLE`, `*_q` registers 1, `row_seen` all 0, window counter 0.
- Write: the memory update is visible to a read one cycle after the write edge is detected.
- Read latency: if CAS is first low on the pins in cycle N with OE low and WE high, `ram_dq_oe=1` and `ram_dq_out` are valid in cycle N+2 (one cycle for the edge register, one for the synchronous RAM).
  - If OE falls later, in cycle M, they are valid in cycle M+2.
- Read release: `ram_dq_oe` falls in cycle K+1, where K is the first cycle CAS or OE is high on the pins.
- Reset mid-cycle: state goes to `IDLE` immediately. `ram_dq_oe` is 0 in the next cycle. A partial write is not committed unless its edge had already been registered.

## Test plan
- Early write then read: RAS fall with addr 8'h12, CAS fall with addr 8'h34 and WE low, dq_in=4'h5. Then read at the same row/col with OE low → `ram_dq_out=4'h5` and `ram_dq_oe=1` exactly two cycles after CAS low; `access_cnt=2`.
- Late write: CAS low with WE high, then WE falls with dq_in=4'hA → readback 4'hA. A second WE toggle in the same CAS period → `proto_err=1`, data stays 4'hA.
- Page mode: one RAS, four CAS pulses at cols 0–3 writing 2,3,4,5, then read back 2,3,4,5; `refresh_cnt` unchanged.
- Refresh: 256 CBR cycles within one window → `refresh_cnt=256`, `refresh_err=0` at window end. Next window has 255 RAS-only refreshes (row 8'h7F omitted) → `refresh_err=1`.
- tRAS violation: RAS low for `TRAS_MIN-1` cycles → `proto_err=1`. RAS low for exactly `TRAS_MIN` cycles → no error.
- Reset during read: assert `rst_n=0` while `ram_dq_oe=1` → next cycle `ram_dq_oe=0`, counters 0; previously written data still reads back correctly.
